// File: rtl/nonogram_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nonogram_level_ctrl
// Purpose  : Level-progression controller for the nonogram game. A check
//            request snapshots the paint grid, then streams the current
//            level's answer rows out of an external synchronous ROM (one row
//            per cycle) and counts mismatching rows. A full match pulses
//            solved/clear_grid and advances the level; after the last level
//            the controller either wraps to level 0 or parks in DONE.
// Ports    : clk, rst         - clock (rising edge), async active-high reset
//            paint_i          - live paint grid, row r = paint_i[r*GRID_W +: GRID_W]
//            check_req_i      - level-sensitive check request, sampled in IDLE
//            ans_addr_o       - ROM address {current_level,row}
//            ans_data_i       - ROM data, valid one cycle after ans_addr_o
//            current_level_o  - active puzzle index
//            busy_o           - check in progress
//            solved_o/fail_o  - one-cycle result pulses
//            err_rows_o       - mismatching-row count of the last check
//            clear_grid_o     - one-cycle wipe request to the grid owner
//            game_done_o      - wrap pulse (WRAP=1) or sticky flag (WRAP=0)
// Revision : 1.0 - initial release
// ============================================================================
module nonogram_level_ctrl #(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int NUM_LEVELS = 3,
  parameter int WRAP       = 1,
  parameter int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int ROW_W      = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [GRID_W*GRID_H-1:0] paint_i,
  input  logic                     check_req_i,
  output logic [LVL_W+ROW_W-1:0]   ans_addr_o,
  input  logic [GRID_W-1:0]        ans_data_i,
  output logic [LVL_W-1:0]         current_level_o,
  output logic                     busy_o,
  output logic                     solved_o,
  output logic                     fail_o,
  output logic [ROW_W:0]           err_rows_o,
  output logic                     clear_grid_o,
  output logic                     game_done_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [GRID_W*GRID_H-1:0]   snap_q, snap_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic                       cmp_vld_q, cmp_vld_d;
  logic [ROW_W-1:0]           cmp_row_q, cmp_row_d;
  logic [ROW_W:0]             err_acc_q, err_acc_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [LVL_W+ROW_W-1:0]     addr_hold_q, addr_hold_d;
  logic                       busy_q, busy_d;
  logic                       solved_q, solved_d;
  logic                       fail_q, fail_d;
  logic                       clear_q, clear_d;
  logic                       done_q, done_d;
  logic [ROW_W:0]             err_rows_q, err_rows_d;

  logic [GRID_W-1:0]          snap_row [GRID_H];
  logic                       row_mismatch;
  logic [ROW_W:0]             err_sum;

  // Unpack the snapshot into rows so the compare stage can index by row.
  generate
    for (genvar r = 0; r < GRID_H; r++) begin : g_snap_rows
      assign snap_row[r] = snap_q[r*GRID_W +: GRID_W];
    end
  endgenerate

  // The ROM answers one cycle late, so the compare stage works on the row
  // addressed in the previous cycle (cmp_row_q), qualified by cmp_vld_q.
  assign row_mismatch = cmp_vld_q && (ans_data_i != snap_row[cmp_row_q]);
  assign err_sum      = err_acc_q + (ROW_W+1)'(row_mismatch);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    row_d       = row_q;
    err_acc_d   = err_acc_q;
    level_d     = level_q;
    addr_hold_d = addr_hold_q;
    busy_d      = busy_q;
    err_rows_d  = err_rows_q;
    solved_d    = 1'b0;
    fail_d      = 1'b0;
    clear_d     = 1'b0;
    // DONE keeps game_done asserted; elsewhere it is a pulse.
    done_d      = (state_q == ST_DONE);
    cmp_vld_d   = (state_q == ST_SCAN);
    cmp_row_d   = row_q;

    case (state_q)
      ST_IDLE: begin
        if (check_req_i) begin
          snap_d    = paint_i;
          row_d     = '0;
          err_acc_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        err_acc_d   = err_sum;
        addr_hold_d = {level_q, row_q};
        if (row_q == LAST_ROW) begin
          state_d = ST_EVAL;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end

      ST_EVAL: begin
        // err_sum folds in the last row's compare, which lands here.
        err_rows_d = err_sum;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
        if (err_sum == '0) begin
          solved_d = 1'b1;
          clear_d  = 1'b1;
          if (level_q != LAST_LVL) begin
            level_d = level_q + LVL_W'(1);
          end else if (WRAP != 0) begin
            level_d = '0;
            done_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          fail_d = 1'b1;
        end
      end

      ST_DONE: begin
        // Absorbing: only rst leaves this state.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      row_q       <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_row_q   <= '0;
      err_acc_q   <= '0;
      level_q     <= '0;
      addr_hold_q <= '0;
      busy_q      <= 1'b0;
      solved_q    <= 1'b0;
      fail_q      <= 1'b0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      err_rows_q  <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      row_q       <= row_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_row_q   <= cmp_row_d;
      err_acc_q   <= err_acc_d;
      level_q     <= level_d;
      addr_hold_q <= addr_hold_d;
      busy_q      <= busy_d;
      solved_q    <= solved_d;
      fail_q      <= fail_d;
      clear_q     <= clear_d;
      done_q      <= done_d;
      err_rows_q  <= err_rows_d;
    end
  end

  // Live address while scanning so the ROM sees each row in its own cycle;
  // otherwise hold the last address that was driven.
  assign ans_addr_o      = (state_q == ST_SCAN) ? {level_q, row_q} : addr_hold_q;
  assign current_level_o = level_q;
  assign busy_o          = busy_q;
  assign solved_o        = solved_q;
  assign fail_o          = fail_q;
  assign err_rows_o      = err_rows_q;
  assign clear_grid_o    = clear_q;
  assign game_done_o     = done_q;

endmodule
`default_nettype wire
